// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the byte-FIFO access arbiter: widths, state and op encodings,
// and the round-robin pick rule.
package fifo_arbiter_pkg;

    localparam int unsigned FIFO_DATA_WIDTH  = 8;
    localparam int unsigned FIFO_COUNT_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_STROBE,
        ST_RD_STROBE,
        ST_WAIT,
        ST_FLUSH_STROBE,
        ST_FLUSH_WAIT
    } arb_state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } arb_op_t;

    // last_grant encoding: which side received the most recent grant
    localparam logic LAST_WRITE = 1'b0;
    localparam logic LAST_READ  = 1'b1;

    // Write wins when it alone is eligible, or on a tie when read was served last.
    function automatic logic rr_pick_write(input logic wr_elig,
                                           input logic rd_elig,
                                           input logic last_grant);
        return wr_elig && (!rd_elig || (last_grant == LAST_READ));
    endfunction

endpackage

// File: rtl/fifo_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fifo_arbiter.sv
// Arbitrates the single-ported byte FIFO between one writer and one reader,
// sequencing each access as a one-cycle strobe plus a busy wait, and drains
// the FIFO on a flush request.
module fifo_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH = FIFO_COUNT_WIDTH,
    parameter int unsigned STALL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_req,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_ack,
    input  logic                   rd_req,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic [COUNT_WIDTH-1:0] flush_count,
    output logic [STALL_WIDTH-1:0] wr_stall_count,
    output logic                   fifo_we,
    output logic                   fifo_re,
    output logic [DATA_WIDTH-1:0]  fifo_data_in,
    input  logic [DATA_WIDTH-1:0]  fifo_data_out,
    input  logic                   fifo_busy,
    input  logic                   fifo_empty,
    input  logic                   fifo_full
);

    arb_state_t            state_q, state_d;
    arb_op_t               op_q, op_d;
    logic                  first_q, first_d;
    logic                  last_grant_q, last_grant_d;
    logic                  flush_pending_q, flush_pending_d;
    logic                  flush_done_q, flush_done_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  wr_elig, rd_elig, access_done;
    logic                  flush_clr, flush_inc;
    logic                  ack_w, valid_r;

    assign wr_elig     = wr_req & ~fifo_full;
    assign rd_elig     = rd_req & ~fifo_empty;
    // The first wait cycle ignores busy: the FIFO may not have raised it yet.
    assign access_done = ~first_q & ~fifo_busy;

    // Next-state, grant decision and strobe/ack generation.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        first_d         = 1'b0;
        last_grant_d    = last_grant_q;
        flush_pending_d = flush_pending_q | flush_req;
        flush_done_d    = 1'b0;
        data_in_d       = data_in_q;
        rd_data_d       = rd_data_q;
        flush_clr       = 1'b0;
        flush_inc       = 1'b0;
        fifo_we         = 1'b0;
        fifo_re         = 1'b0;
        ack_w           = 1'b0;
        valid_r         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_busy) begin
                    if (flush_pending_q) begin
                        // A flush pulse arriving on the entry cycle re-arms for a later drain.
                        flush_pending_d = flush_req;
                        flush_clr       = 1'b1;
                        if (fifo_empty) begin
                            flush_done_d = 1'b1;
                        end else begin
                            state_d = ST_FLUSH_STROBE;
                        end
                    end else if (rr_pick_write(wr_elig, rd_elig, last_grant_q)) begin
                        state_d      = ST_WR_STROBE;
                        data_in_d    = wr_data;
                        last_grant_d = LAST_WRITE;
                    end else if (rd_elig) begin
                        state_d      = ST_RD_STROBE;
                        last_grant_d = LAST_READ;
                    end
                end
            end
            ST_WR_STROBE: begin
                fifo_we = 1'b1;
                op_d    = OP_WRITE;
                first_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_RD_STROBE: begin
                fifo_re = 1'b1;
                op_d    = OP_READ;
                first_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (access_done) begin
                    state_d = ST_IDLE;
                    if (op_q == OP_WRITE) begin
                        ack_w = 1'b1;
                    end else begin
                        valid_r   = 1'b1;
                        rd_data_d = fifo_data_out;
                    end
                end
            end
            ST_FLUSH_STROBE: begin
                fifo_re = 1'b1;
                first_d = 1'b1;
                state_d = ST_FLUSH_WAIT;
            end
            ST_FLUSH_WAIT: begin
                if (access_done) begin
                    flush_inc = 1'b1;
                    if (!fifo_empty) begin
                        state_d = ST_FLUSH_STROBE;
                    end else begin
                        state_d      = ST_IDLE;
                        flush_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Acks are issued in the last wait cycle so the requester can drop before IDLE
    // samples it again; a reset in that cycle suppresses them.
    assign wr_ack   = ack_w & ~reset;
    assign rd_valid = valid_r & ~reset;
    assign rd_data  = rd_valid ? fifo_data_out : rd_data_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            op_q            <= OP_WRITE;
            first_q         <= 1'b0;
            last_grant_q    <= LAST_READ;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
            data_in_q       <= '0;
            rd_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            first_q         <= first_d;
            last_grant_q    <= last_grant_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
            data_in_q       <= data_in_d;
            rd_data_q       <= rd_data_d;
        end
    end

    assign flush_done   = flush_done_q;
    assign fifo_data_in = data_in_q;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush_clr),
        .inc_i   (flush_inc),
        .count_o (flush_count)
    );

    sat_counter #(.WIDTH(STALL_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (1'b0),
        .inc_i   (wr_req & fifo_full),
        .count_o (wr_stall_count)
    );

endmodule

// File: tb/tb_fifo_arbiter.sv
// Scoreboard bench for fifo_arbiter with a behavioural byte FIFO attached.
module tb_fifo_arbiter;

    localparam int CAP = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0, rd_req = 1'b0, flush_req = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ack, rd_valid, flush_done, fifo_we, fifo_re;
    logic [7:0] rd_data, fifo_data_in;
    logic [9:0] flush_count;
    logic [7:0] wr_stall_count;
    logic [7:0] fifo_data_out = '0;
    logic       fifo_busy = 1'b0, fifo_empty = 1'b1, fifo_full = 1'b0;

    fifo_arbiter #(.DATA_WIDTH(8), .COUNT_WIDTH(10), .STALL_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .flush_req(flush_req), .flush_done(flush_done), .flush_count(flush_count),
        .wr_stall_count(wr_stall_count),
        .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_data_in(fifo_data_in),
        .fifo_data_out(fifo_data_out), .fifo_busy(fifo_busy),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0, n_total = 0;
    int unsigned n_we = 0, n_re = 0, n_rdv = 0, n_ack = 0, n_fd = 0;
    logic [7:0] exp_we_q[$], exp_rd_q[$], exp_grant_q[$], model_q[$], fq[$];
    int busy_cnt = 0, busy_max = 0, busy_one = -1;
    logic [7:0] last_rd;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Behavioural FIFO: strobes act at the falling edge, busy then stays high for a chosen number of cycles.
    always @(negedge clk) begin
        if (busy_cnt > 0) busy_cnt--;
        if (fifo_we || fifo_re) begin
            if (fifo_we && fq.size() < CAP) fq.push_back(fifo_data_in);
            if (fifo_re && fq.size() > 0) fifo_data_out = fq.pop_front();
            if (busy_one >= 0) begin busy_cnt = busy_one; busy_one = -1; end
            else busy_cnt = $urandom_range(busy_max, 0);
        end
        fifo_busy  = (busy_cnt > 0);
        fifo_empty = (fq.size() == 0);
        fifo_full  = (fq.size() >= CAP);
    end

    // Monitor: pops scoreboard entries whenever the DUT presents a strobe or response.
    always begin
        @(negedge clk); #1;
        if (fifo_we || fifo_re) chk("strobe_exclusive", 64'(fifo_we & fifo_re), 64'd0);
        if ((fifo_we || fifo_re) && exp_grant_q.size() != 0)
            chk("grant_order", fifo_we ? 64'h57 : 64'h52, 64'(exp_grant_q.pop_front()));
        if (fifo_we) begin
            n_we++;
            chk("we_expected", 64'(exp_we_q.size() != 0), 64'd1);
            if (exp_we_q.size() != 0) chk("we_data", 64'(fifo_data_in), 64'(exp_we_q.pop_front()));
        end
        if (fifo_re) n_re++;
        if (rd_valid) begin
            n_rdv++;
            chk("rdv_busy_low", 64'(fifo_busy), 64'd0);
            chk("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
            if (exp_rd_q.size() != 0) chk("rd_data", 64'(rd_data), 64'(exp_rd_q.pop_front()));
        end
        if (wr_ack) begin
            n_ack++;
            chk("ack_busy_low", 64'(fifo_busy), 64'd0);
        end
        if (flush_done) n_fd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic wr_access(input logic [7:0] b, output int lat);
        wr_data = b; wr_req = 1'b1; exp_we_q.push_back(b); lat = -1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk); #1;
            if (wr_ack) begin lat = n; break; end
        end
        chk("wr_ack_seen", 64'(lat >= 0), 64'd1);
        if (lat >= 0) model_q.push_back(b);
        @(posedge clk); #1; wr_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_access(output int lat);
        logic [7:0] e;
        e = model_q.pop_front(); exp_rd_q.push_back(e); last_rd = e;
        rd_req = 1'b1; lat = -1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk); #1;
            if (rd_valid) begin lat = n; break; end
        end
        chk("rd_valid_seen", 64'(lat >= 0), 64'd1);
        @(posedge clk); #1; rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1; @(posedge clk); #1; flush_req = 1'b0;
    endtask

    task automatic wait_flush(output int cnt);
        cnt = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if (flush_done) begin cnt = int'(flush_count); break; end
        end
        chk("flush_done_seen", 64'(cnt >= 0), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {wr_ack, rd_valid, flush_done, fifo_we, fifo_re, rd_data, flush_count,
                   wr_stall_count, fifo_data_in}, 64'd0);
    endtask

    initial begin
        int lat, cnt, exp_cnt, re0, we0, rdv0, fd0, ack0;
        logic [7:0] b;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk); #1;
        check_outputs_zero("reset_outputs");
        @(posedge clk); #1; reset = 1'b0;

        // Single write, idle FIFO: ack three cycles after the request is seen
        wr_access(8'hA5, lat);
        chk("wr_latency", 64'(lat), 64'd3);

        // Read with busy stretched for 5 cycles after the strobe
        busy_one = 5;
        rd_access(lat);
        chk("rd_latency_busy", 64'(lat), 64'((5 + 1 > 3) ? 5 + 1 : 3));
        @(negedge clk); #1;
        chk("rd_data_hold", 64'(rd_data), 64'(last_rd));
        @(posedge clk); #1;

        // Empty FIFO: a held read request produces no strobe
        re0 = n_re;
        rd_req = 1'b1;
        repeat (20) @(posedge clk);
        #1; rd_req = 1'b0;
        @(posedge clk); #1;
        chk("empty_no_re", 64'(n_re - re0), 64'd0);

        // Flush of an already-empty FIFO
        re0 = n_re; exp_cnt = model_q.size();
        pulse_flush();
        wait_flush(cnt);
        chk("flush_empty_count", 64'(cnt), 64'(exp_cnt));
        chk("flush_empty_no_re", 64'(n_re - re0), 64'd0);

        // Contention after reset with the FIFO half full: W,R,W,R,W,R
        for (int i = 0; i < CAP / 2; i++) wr_access(8'($urandom), lat);
        do_reset();
        repeat (3) begin exp_grant_q.push_back(8'h57); exp_grant_q.push_back(8'h52); end
        fork
            for (int i = 0; i < 3; i++) wr_access(8'($urandom), lat);
            for (int i = 0; i < 3; i++) rd_access(lat);
        join
        chk("grant_order_consumed", 64'(exp_grant_q.size()), 64'd0);

        // Randomised traffic with random busy stretches
        busy_max = 3;
        fork
            for (int i = 0; i < 20; i++) begin
                wr_access(8'($urandom), lat);
                repeat ($urandom_range(3, 0)) @(posedge clk);
            end
            for (int i = 0; i < 20; i++) begin
                for (int w = 0; w < 1000 && model_q.size() == 0; w++) @(posedge clk);
                #1;
                chk("rd_model_ready", 64'(model_q.size() != 0), 64'd1);
                if (model_q.size() != 0) rd_access(lat);
                repeat ($urandom_range(3, 0)) @(posedge clk);
                #1;
            end
        join

        // Drain whatever is left, then flush 7 bytes with the pulse landing mid-write
        exp_cnt = model_q.size();
        pulse_flush();
        wait_flush(cnt);
        chk("flush_drain_count", 64'(cnt), 64'(exp_cnt));
        model_q.delete();
        for (int i = 0; i < 6; i++) wr_access(8'($urandom), lat);
        re0 = n_re; rdv0 = n_rdv; fd0 = n_fd; we0 = n_we;
        fork
            wr_access(8'h77, lat);
            begin
                for (int w = 0; w < 100 && n_we == we0; w++) begin @(posedge clk); #1; end
                pulse_flush();
            end
        join
        chk("flush_after_ack_no_re", 64'(n_re - re0), 64'd0);
        exp_cnt = model_q.size();
        wait_flush(cnt);
        chk("flush_count_7", 64'(cnt), 64'(exp_cnt));
        repeat (4) @(posedge clk);
        #1;
        chk("flush_re_pulses", 64'(n_re - re0), 64'(exp_cnt));
        chk("flush_done_once", 64'(n_fd - fd0), 64'd1);
        chk("flush_no_rd_valid", 64'(n_rdv - rdv0), 64'd0);
        model_q.delete();

        // Full FIFO: held write stalls and the stall counter saturates
        busy_max = 0;
        for (int i = 0; i < CAP; i++) wr_access(8'($urandom), lat);
        do_reset();
        we0 = n_we;
        wr_data = 8'hEE; wr_req = 1'b1;
        repeat (300) @(posedge clk);
        #1; wr_req = 1'b0;
        @(posedge clk); #1;
        chk("full_no_we", 64'(n_we - we0), 64'd0);
        chk("stall_saturated", 64'(wr_stall_count), 64'd255);
        exp_cnt = model_q.size();
        pulse_flush();
        wait_flush(cnt);
        chk("flush_full_count", 64'(cnt), 64'(exp_cnt));
        model_q.delete();

        // Reset in the last wait cycle of a write: no ack, everything cleared
        ack0 = n_ack;
        b = 8'h3C;
        wr_data = b; wr_req = 1'b1; exp_we_q.push_back(b);
        for (int n = 0; n < 20; n++) begin @(negedge clk); #1; if (fifo_we) break; end
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; wr_req = 1'b0;
        @(negedge clk); #1;
        check_outputs_zero("reset_mid_wait_outputs");
        @(posedge clk); #1;
        chk("reset_no_ack", 64'(n_ack - ack0), 64'd0);
        model_q.push_back(b);

        // Ties: write first after reset, read first after a lone write
        exp_grant_q.push_back(8'h57); exp_grant_q.push_back(8'h52);
        fork
            wr_access(8'h11, lat);
            rd_access(lat);
        join
        wr_access(8'h22, lat);
        exp_grant_q.push_back(8'h52); exp_grant_q.push_back(8'h57);
        fork
            wr_access(8'h33, lat);
            rd_access(lat);
        join
        chk("tie_grants_consumed", 64'(exp_grant_q.size()), 64'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("we_scoreboard_empty", 64'(exp_we_q.size()), 64'd0);
        chk("rd_scoreboard_empty", 64'(exp_rd_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Shares the single-ported byte FIFO between one write requester (the switch/CRC capture path) and one read requester (the FIFO-to-UART path). Grants alternate round-robin when both sides are pending. Each access is sequenced as a one-cycle strobe followed by a wait for the FIFO busy flag to clear. A flush request drains the FIFO. The block replaces the free-running always-on enables in the task top levels and sits directly between the requesters and the FIFO instance.

## Interface
- DATA_WIDTH, 8, byte width of the FIFO data path
- COUNT_WIDTH, 10, width of the flush discard counter (matches the FIFO count width)
- STALL_WIDTH, 8, width of the saturating write-stall counter

- clk  input  1  single system clock (UART-rate clock); all logic on its rising edge
- reset  input  1  synchronous, active-high
- wr_req  input  1  write requester holds high until wr_ack
- wr_data  input  DATA_WIDTH  byte to write; must be stable while wr_req is high
- wr_ack  output  1  one-cycle pulse when the write has completed
- rd_req  input  1  read requester holds high until rd_valid
- rd_data  output  DATA_WIDTH  byte read; held until the next read completes
- rd_valid  output  1  one-cycle pulse when rd_data is updated
- flush_req  input  1  one-cycle pulse that requests a drain
- flush_done  output  1  one-cycle pulse when the FIFO is empty after a flush
- flush_count  output  COUNT_WIDTH  bytes discarded by the last flush
- wr_stall_count  output  STALL_WIDTH  saturating count of cycles with wr_req high while fifo_full
- fifo_we, fifo_re  output  1  one-cycle access strobes to the FIFO
- fifo_data_in  output  DATA_WIDTH  registered copy of wr_data
- fifo_data_out  input  DATA_WIDTH  FIFO read data, valid when busy clears after fifo_re
- fifo_busy, fifo_empty, fifo_full  input  1  FIFO status flags

## Operation
- States: IDLE, WR_STROBE, RD_STROBE, WAIT, FLUSH_STROBE, FLUSH_WAIT.
- IDLE grant priority, highest first:
  - Latched flush request, which always wins.
  - Eligible requesters in round-robin order. Write is eligible when wr_req=1 and fifo_full=0. Read is eligible when rd_req=1 and fifo_empty=0.
  - A grant also requires fifo_busy=0.
- Round-robin:
  - last_grant bit: 0 means write was granted last, 1 means read was granted last.
  - When both sides are eligible, the side not granted last wins.
  - When one side is eligible, it wins regardless of last_grant.
- WR_STROBE:
  - fifo_we=1 for exactly one cycle; fifo_data_in is captured from wr_data on entry.
  - Next state is WAIT with op=write.
- RD_STROBE: fifo_re=1 for one cycle, then WAIT with op=read.
- WAIT:
  - Ignore fifo_busy in the first WAIT cycle.
  - From the second cycle onward, when fifo_busy=0, finish the access and return to IDLE.
  - Write finish: wr_ack pulses.
  - Read finish: rd_data is loaded from fifo_data_out and rd_valid pulses.
- flush_req:
  - Latched into flush_pending on any cycle, in any state.
  - Taken only from IDLE, so an in-flight access always completes first.
- Flush entry: clears flush_count.
- Flush, FIFO already empty: go straight to IDLE and pulse flush_done with flush_count=0.
- Flush loop:
  - FLUSH_STROBE pulses fifo_re.
  - FLUSH_WAIT uses the same busy rule as WAIT, then increments flush_count.
  - Loop back to FLUSH_STROBE while fifo_empty=0; otherwise go to IDLE and pulse flush_done.
- Flush side effects:
  - Discarded bytes never reach rd_data.
  - Requests arriving during a flush stay pending.
- flush_count saturates at all-ones.
- wr_stall_count increments every cycle with wr_req&fifo_full, saturates at all-ones, and is cleared only by reset.

## Timing
- Reset values: all outputs 0; state IDLE; last_grant=1, so write wins the first tie; flush_pending=0.
- Reset is honoured in any state, including mid-access: strobes drop on the next edge and no ack is issued.
- Minimum access latency, wr_req rise to wr_ack, with fifo_busy idle: 3 cycles (IDLE grant, STROBE, WAIT at least 2 cycles, ack on the WAIT exit edge). Read latency is identical.
- Strobe rules:
  - fifo_we and fifo_re are never high in the same cycle.
  - Each strobe is high for exactly one cycle per access.
- Ack rules:
  - Requesters drop their request on the cycle after the ack.
  - A request still high in the ack cycle is not re-granted in that same cycle, because IDLE is re-entered on the next edge.
- Full/empty are sampled only in IDLE. A side that becomes ineligible after its grant still completes its access.

## Structure
- Shared package/header: state encodings, the op encoding (OP_WRITE/OP_READ), and the DATA_WIDTH and COUNT_WIDTH defaults shared with the FIFO.
- A single flat module. The saturating counter is reused twice, so one optional sub-module, sat_counter, is allowed.

## Test plan
- Single write: wr_req with wr_data=8'hA5, busy idle → fifo_we pulse with fifo_data_in=A5, then wr_ack 3 cycles after wr_req.
- Contention: wr_req and rd_req both held, FIFO half full → grant order W,R,W,R; never two consecutive grants to one side.
- Full and empty: fifo_full=1 with wr_req for 300 cycles → no fifo_we and wr_stall_count=255 (saturated). fifo_empty=1 with rd_req → no fifo_re.
- Busy stretch: fifo_busy held 5 cycles after a strobe → rd_valid only after busy falls, and rd_data equals fifo_data_out at that edge.
- Flush: FIFO holds 7 bytes and flush_req pulses during a write → the write acks first, then 7 fifo_re pulses, flush_count=7, flush_done once, rd_valid never.
- Reset during WAIT: reset high for 1 cycle → outputs all 0, no wr_ack, and the next tie grants write first.
